// File: rtl/axi_arb_pkg.sv
// Shared types for the two-master AXI4-Lite arbiter: FSM states and response codes.
package axi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite bundle. 'master' drives requests, 'slave' answers them.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid, awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid, wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid, bready;
  logic [1:0]              bresp;
  logic                    arvalid, arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid, rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. Holds the last served master; master 0 wins first after reset.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last,
  output logic       gnt
);
  logic last_q, last_d;

  // pointer only moves when a transaction retires
  always_comb begin
    last_d = update ? last : last_q;
  end

  // last-served register, reset so master 0 is preferred
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end

  // both requesting -> the one not served last; otherwise whoever asks
  always_comb begin
    case (req)
      2'b11:   gnt = ~last_q;
      2'b10:   gnt = 1'b1;
      default: gnt = 1'b0;
    endcase
  end
endmodule

// File: rtl/axi_lite_arbiter.sv
// Two upstream AXI4-Lite masters share one downstream port, one transaction at a time.
module axi_lite_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  axi_lite_if.slave  m0,
  axi_lite_if.slave  m1,
  axi_lite_if.master s,
  output logic     grant,
  output logic     busy
);
  localparam int SW = DATA_WIDTH / 8;

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic       upd, arb_gnt;
  logic [1:0] req;

  // upstream inputs gathered per master so the granted one is a simple index
  logic [1:0]                 up_awvalid, up_wvalid, up_bready, up_arvalid, up_rready;
  logic [1:0][ADDR_WIDTH-1:0] up_awaddr, up_araddr;
  logic [1:0][2:0]            up_awprot, up_arprot;
  logic [1:0][DATA_WIDTH-1:0] up_wdata;
  logic [1:0][SW-1:0]         up_wstrb;
  // upstream outputs, zero for whoever is not granted
  logic [1:0]                 up_awready, up_wready, up_bvalid, up_arready, up_rvalid;
  logic [1:0][1:0]            up_bresp, up_rresp;
  logic [1:0][DATA_WIDTH-1:0] up_rdata;
  // downstream handshake terms
  logic s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;

  assign up_awvalid = {m1.awvalid, m0.awvalid};
  assign up_wvalid  = {m1.wvalid,  m0.wvalid};
  assign up_bready  = {m1.bready,  m0.bready};
  assign up_arvalid = {m1.arvalid, m0.arvalid};
  assign up_rready  = {m1.rready,  m0.rready};
  assign up_awaddr  = {m1.awaddr,  m0.awaddr};
  assign up_araddr  = {m1.araddr,  m0.araddr};
  assign up_awprot  = {m1.awprot,  m0.awprot};
  assign up_arprot  = {m1.arprot,  m0.arprot};
  assign up_wdata   = {m1.wdata,   m0.wdata};
  assign up_wstrb   = {m1.wstrb,   m0.wstrb};

  assign m0.awready = up_awready[0];  assign m1.awready = up_awready[1];
  assign m0.wready  = up_wready[0];   assign m1.wready  = up_wready[1];
  assign m0.bvalid  = up_bvalid[0];   assign m1.bvalid  = up_bvalid[1];
  assign m0.bresp   = up_bresp[0];    assign m1.bresp   = up_bresp[1];
  assign m0.arready = up_arready[0];  assign m1.arready = up_arready[1];
  assign m0.rvalid  = up_rvalid[0];   assign m1.rvalid  = up_rvalid[1];
  assign m0.rdata   = up_rdata[0];    assign m1.rdata   = up_rdata[1];
  assign m0.rresp   = up_rresp[0];    assign m1.rresp   = up_rresp[1];

  // payloads follow the grant; only the valids are phase-gated
  assign s.awvalid = s_awvalid;
  assign s.awaddr  = up_awaddr[grant_q];
  assign s.awprot  = up_awprot[grant_q];
  assign s.wvalid  = s_wvalid;
  assign s.wdata   = up_wdata[grant_q];
  assign s.wstrb   = up_wstrb[grant_q];
  assign s.bready  = s_bready;
  assign s.arvalid = s_arvalid;
  assign s.araddr  = up_araddr[grant_q];
  assign s.arprot  = up_arprot[grant_q];
  assign s.rready  = s_rready;

  assign req   = up_awvalid | up_arvalid;
  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

  rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .update (upd),
    .last   (grant_q),
    .gnt    (arb_gnt)
  );

  // next state, channel routing and per-channel done tracking
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    upd        = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    up_awready = '0;
    up_wready  = '0;
    up_bvalid  = '0;
    up_bresp   = '0;
    up_arready = '0;
    up_rvalid  = '0;
    up_rdata   = '0;
    up_rresp   = '0;
    case (state_q)
      IDLE: begin
        // kind is carried by the next state: write wins inside the granted master
        if (|req) begin
          grant_d   = arb_gnt;
          state_d   = up_awvalid[arb_gnt] ? WADDR : RADDR;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WADDR: begin
        // AW and W complete independently; a finished channel is closed both ways
        s_awvalid           = up_awvalid[grant_q] & ~aw_done_q;
        s_wvalid            = up_wvalid[grant_q]  & ~w_done_q;
        up_awready[grant_q] = s.awready & ~aw_done_q;
        up_wready[grant_q]  = s.wready  & ~w_done_q;
        aw_done_d           = aw_done_q | (s_awvalid & s.awready);
        w_done_d            = w_done_q  | (s_wvalid  & s.wready);
        if (aw_done_d && w_done_d) begin
          state_d   = WRESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WRESP: begin
        s_bready           = up_bready[grant_q];
        up_bvalid[grant_q] = s.bvalid;
        up_bresp[grant_q]  = s.bresp;
        if (s.bvalid && s_bready) begin
          state_d = IDLE;
          upd     = 1'b1;
        end
      end
      RADDR: begin
        s_arvalid           = up_arvalid[grant_q];
        up_arready[grant_q] = s.arready;
        if (s_arvalid && s.arready) state_d = RDATA;
      end
      RDATA: begin
        s_rready           = up_rready[grant_q];
        up_rvalid[grant_q] = s.rvalid;
        up_rdata[grant_q]  = s.rdata;
        up_rresp[grant_q]  = s.rresp;
        if (s.rvalid && s_rready) begin
          state_d = IDLE;
          upd     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, grant and done flags; reset drops any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench: inputs change on the falling edge, outputs are sampled 1ns later.
module tb_axi_lite_arbiter;
  import axi_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic grant, busy;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .grant (grant),
    .busy  (busy)
  );

  // master-side drive and observe, index = master
  logic [1:0]       awv, wv, bry, arv, rry;
  logic [1:0][31:0] awa, wd, ara;
  logic [1:0]       awr, wr, bv, arr, rv;
  logic [1:0][1:0]  br, rr;
  logic [1:0][31:0] rd;
  // downstream slave model
  logic        sawr, swr, sbv, sarr, srv;
  logic [1:0]  sbr, srr;
  logic [31:0] srd;

  assign m0_if.awvalid = awv[0];  assign m1_if.awvalid = awv[1];
  assign m0_if.awaddr  = awa[0];  assign m1_if.awaddr  = awa[1];
  assign m0_if.awprot  = 3'd1;    assign m1_if.awprot  = 3'd2;
  assign m0_if.wvalid  = wv[0];   assign m1_if.wvalid  = wv[1];
  assign m0_if.wdata   = wd[0];   assign m1_if.wdata   = wd[1];
  assign m0_if.wstrb   = 4'hF;    assign m1_if.wstrb   = 4'h3;
  assign m0_if.bready  = bry[0];  assign m1_if.bready  = bry[1];
  assign m0_if.arvalid = arv[0];  assign m1_if.arvalid = arv[1];
  assign m0_if.araddr  = ara[0];  assign m1_if.araddr  = ara[1];
  assign m0_if.arprot  = 3'd0;    assign m1_if.arprot  = 3'd4;
  assign m0_if.rready  = rry[0];  assign m1_if.rready  = rry[1];

  assign awr = {m1_if.awready, m0_if.awready};
  assign wr  = {m1_if.wready,  m0_if.wready};
  assign bv  = {m1_if.bvalid,  m0_if.bvalid};
  assign arr = {m1_if.arready, m0_if.arready};
  assign rv  = {m1_if.rvalid,  m0_if.rvalid};
  assign br  = {m1_if.bresp,   m0_if.bresp};
  assign rr  = {m1_if.rresp,   m0_if.rresp};
  assign rd  = {m1_if.rdata,   m0_if.rdata};

  assign s_if.awready = sawr;
  assign s_if.wready  = swr;
  assign s_if.bvalid  = sbv;
  assign s_if.bresp   = sbr;
  assign s_if.arready = sarr;
  assign s_if.rvalid  = srv;
  assign s_if.rdata   = srd;
  assign s_if.rresp   = srr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int  seen;
    int  cyc;
    logic expg;
    awv = '0; wv = '0; bry = '0; arv = '0; rry = '0;
    awa = '0; wd = '0; ara = '0;
    sawr = 0; swr = 0; sbv = 0; sarr = 0; srv = 0;
    sbr = RESP_OKAY; srr = RESP_OKAY; srd = '0;

    // reset state
    #3;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_saw",   64'(s_if.awvalid), 64'd0);
    chk("rst_sar",   64'(s_if.arvalid), 64'd0);
    chk("rst_awr",   64'(awr), 64'd0);
    @(negedge clk); rst = 1'b1;

    // m0 lone write
    @(negedge clk);
    awv[0] = 1; awa[0] = 32'h10; wv[0] = 1; wd[0] = 32'hA5; sawr = 1; swr = 1; #1;
    chk("t1_idle_saw", 64'(s_if.awvalid), 64'd0);
    @(negedge clk); #1;
    chk("t1_busy",  64'(busy), 64'd1);
    chk("t1_grant", 64'(grant), 64'd0);
    chk("t1_saw",   64'(s_if.awvalid), 64'd1);
    chk("t1_saddr", 64'(s_if.awaddr), 64'h10);
    chk("t1_sw",    64'(s_if.wvalid), 64'd1);
    chk("t1_sdata", 64'(s_if.wdata), 64'hA5);
    chk("t1_sprot", 64'(s_if.awprot), 64'd1);
    chk("t1_awr",   64'(awr), 64'b01);
    @(negedge clk);
    awv = '0; wv = '0; sbv = 1; sbr = RESP_OKAY; bry = 2'b01; #1;
    chk("t1_bv",  64'(bv), 64'b01);
    chk("t1_saw_off", 64'(s_if.awvalid), 64'd0);
    @(negedge clk); sbv = 0; #1;
    chk("t1_idle", 64'(busy), 64'd0);

    // fresh reset, then simultaneous reads
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    arv = 2'b11; ara[0] = 32'h100; ara[1] = 32'h200; sarr = 1; rry = 2'b11; #1;
    @(negedge clk); #1;
    chk("t2_g0",    64'(grant), 64'd0);
    chk("t2_sar",   64'(s_if.arvalid), 64'd1);
    chk("t2_addr0", 64'(s_if.araddr), 64'h100);
    chk("t2_arr0",  64'(arr), 64'b01);
    @(negedge clk);
    arv[0] = 0; srv = 1; srd = 32'h1111; #1;
    chk("t2_rv0",  64'(rv), 64'b01);
    chk("t2_rd0",  64'(rd[0]), 64'h1111);
    chk("t2_rd1z", 64'(rd[1]), 64'd0);
    @(negedge clk); srv = 0; #1;
    chk("t2_gap", 64'(busy), 64'd0);
    @(negedge clk); #1;
    chk("t2_g1",    64'(grant), 64'd1);
    chk("t2_addr1", 64'(s_if.araddr), 64'h200);
    chk("t2_arr1",  64'(arr), 64'b10);
    @(negedge clk);
    arv[1] = 0; srv = 1; srd = 32'h2222; #1;
    chk("t2_rv1", 64'(rv), 64'b10);
    chk("t2_rd1", 64'(rd[1]), 64'h2222);
    @(negedge clk); srv = 0; #1;
    chk("t2_done", 64'(busy), 64'd0);

    // m1 write, W arrives three cycles after AW
    @(negedge clk);
    awv[1] = 1; awa[1] = 32'h30; wv = '0; sawr = 1; swr = 1; #1;
    @(negedge clk); #1;
    chk("t3_grant", 64'(grant), 64'd1);
    chk("t3_saw",   64'(s_if.awvalid), 64'd1);
    chk("t3_saddr", 64'(s_if.awaddr), 64'h30);
    chk("t3_sw0",   64'(s_if.wvalid), 64'd0);
    @(negedge clk);
    awv[1] = 0; sbv = 1; sbr = RESP_OKAY; bry = 2'b10; #1;
    chk("t3_awr_done", 64'(awr), 64'd0);
    chk("t3_saw_done", 64'(s_if.awvalid), 64'd0);
    chk("t3_no_bv",    64'(bv), 64'd0);
    @(negedge clk);
    wv[1] = 1; wd[1] = 32'h5A; #1;
    chk("t3_wr",     64'(wr), 64'b10);
    chk("t3_sdata",  64'(s_if.wdata), 64'h5A);
    chk("t3_no_bv2", 64'(bv), 64'd0);
    @(negedge clk); wv = '0; #1;
    chk("t3_bv", 64'(bv), 64'b10);
    @(negedge clk); sbv = 0; #1;
    chk("t3_done", 64'(busy), 64'd0);

    // m0 write answered with SLVERR
    @(negedge clk);
    awv[0] = 1; awa[0] = 32'h40; wv[0] = 1; wd[0] = 32'h77; bry = 2'b11; #1;
    @(negedge clk); #1;
    chk("t4_sdata", 64'(s_if.wdata), 64'h77);
    @(negedge clk);
    awv = '0; wv = '0; sbv = 1; sbr = RESP_SLVERR; #1;
    chk("t4_br0", 64'(br[0]), 64'h2);
    chk("t4_br1", 64'(br[1]), 64'h0);
    chk("t4_bv",  64'(bv), 64'b01);
    @(negedge clk); sbv = 0; sbr = RESP_OKAY; #1;
    chk("t4_br0_idle", 64'(br[0]), 64'h0);

    // both masters hammer reads: grants alternate, m1 first (m0 served last)
    arv = 2'b11; rry = 2'b11; sarr = 1; srv = 1; srd = 32'hCAFE;
    seen = 0; cyc = 0; expg = 1'b1;
    while (seen < 8 && cyc < 100) begin
      @(negedge clk); #1; cyc++;
      if (s_if.arvalid) begin
        chk("t5_grant", 64'(grant), 64'(expg));
        chk("t5_other_arr", 64'(arr[!grant]), 64'd0);
        expg = ~expg;
        seen++;
      end
    end
    if (seen < 8) chk("t5_timeout", 64'(seen), 64'd8);
    @(negedge clk); arv = '0;
    @(negedge clk); srv = 0; #1;
    chk("t5_done", 64'(busy), 64'd0);

    // reset while in RDATA
    @(negedge clk);
    arv = 2'b10; ara[1] = 32'h600; rry = '0; #1;
    @(negedge clk); #1;
    chk("t6_g1", 64'(grant), 64'd1);
    @(negedge clk);
    arv = '0; srv = 1; srd = 32'hDEAD; #1;
    chk("t6_rv",   64'(rv), 64'b10);
    chk("t6_busy", 64'(busy), 64'd1);
    #2 rst = 1'b0; #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_rv",   64'(rv), 64'd0);
    chk("t6_rst_srr",  64'(s_if.rready), 64'd0);
    chk("t6_rst_g",    64'(grant), 64'd0);
    @(negedge clk);
    rst = 1'b1; srv = 0; arv = 2'b11; ara[0] = 32'h500; #1;
    chk("t6_idle_sar", 64'(s_if.arvalid), 64'd0);
    @(negedge clk); #1;
    chk("t6_g0",    64'(grant), 64'd0);
    chk("t6_addr0", 64'(s_if.araddr), 64'h500);
    @(negedge clk);
    arv = '0; srv = 1; srd = 32'h3333; rry = 2'b11; #1;
    chk("t6_rd0",  64'(rd[0]), 64'h3333);
    chk("t6_rd1z", 64'(rd[1]), 64'd0);
    chk("t6_rr0",  64'(rr[0]), 64'(RESP_OKAY));
    @(negedge clk); srv = 0; #1;
    chk("t6_done", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of all AW/AR channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width of W/R channels; strobe width DATA_WIDTH/8.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports m0_/m1_ awvalid in 1, awready out 1, awaddr in ADDR_WIDTH, awprot in 3: upstream write address, per master.
REQ-006 SHALL have ports m0_/m1_ wvalid in 1, wready out 1, wdata in DATA_WIDTH, wstrb in DATA_WIDTH/8: upstream write data.
REQ-007 SHALL have ports m0_/m1_ bvalid out 1, bready in 1, bresp out 2: upstream write response.
REQ-008 SHALL have ports m0_/m1_ arvalid in 1, arready out 1, araddr in ADDR_WIDTH, arprot in 3: upstream read address.
REQ-009 SHALL have ports m0_/m1_ rvalid out 1, rready in 1, rdata out DATA_WIDTH, rresp out 2: upstream read data.
REQ-010 SHALL have ports s_aw*, s_w*, s_b*, s_ar*, s_r* with directions mirrored and widths as above: downstream AXI4-Lite master port driving the APB bridge slave port.
REQ-011 SHALL have ports grant out 1 (granted master index) and busy out 1 (state != IDLE).

Function
REQ-012 SHALL permit exactly one outstanding transaction (read or write) downstream at any time.
REQ-013 SHALL use FSM states IDLE, WADDR, WRESP, RADDR, RDATA.
REQ-014 SHALL treat master i as requesting when mi_awvalid or mi_arvalid is high in IDLE.
REQ-015 SHALL, in IDLE with both requesting, grant the master not equal to last_grant; with one requesting, grant it.
REQ-016 SHALL, within the granted master, select write when awvalid is high, else read.
REQ-017 SHALL register grant and kind in IDLE; first downstream valid appears the following cycle (1-cycle arbitration latency).
REQ-018 SHALL in WADDR forward granted AW and W channels combinationally and independently; track aw_done and w_done flags; move to WRESP when both complete (same-cycle completion allowed).
REQ-019 SHALL in WRESP forward s_b* to granted master; on bvalid&bready go to IDLE and set last_grant to grant.
REQ-020 SHALL in RADDR forward AR channel; on arvalid&arready go to RDATA.
REQ-021 SHALL in RDATA forward s_r* to granted master; on rvalid&rready go to IDLE and set last_grant.
REQ-022 SHALL hold all ready/valid outputs to the non-granted master, and all downstream valids outside the active phase, at 0.
REQ-023 SHALL never drop or duplicate a handshake; a channel already done (aw_done/w_done) SHALL see ready=0 upstream and valid=0 downstream.
REQ-024 SHALL drive non-granted response data/resp outputs to 0.

Reset
REQ-025 SHALL on rst low immediately set state IDLE, grant 0, last_grant 1 (master 0 wins first), aw_done/w_done 0, busy 0, all valid/ready outputs 0.
REQ-026 SHALL on reset mid-transaction abandon it with no response issued; the bridge shares the same reset.

Structure
REQ-027 SHALL place the state enum and AXI response codes (OKAY=2'b00, SLVERR=2'b10) in package axi_arb_pkg.
REQ-028 SHALL implement the 2-way round-robin pointer as sub-module rr_arb2 (req[1:0], update, last -> gnt).

Verification
REQ-029 Bench: m0 writes awaddr=0x10, wdata=0xA5 alone -> s_awaddr=0x10, s_wdata=0xA5 one cycle after request, m0_bvalid on s_bvalid.
REQ-030 Bench: m0 and m1 both arvalid same cycle after reset -> m0 served first, m1 served next, grant toggles 0,1.
REQ-031 Bench: m1 write with W presented 3 cycles after AW -> WRESP entered only after W handshake; m1_awready low after AW done.
REQ-032 Bench: s_bresp=SLVERR during m0 write -> m0_bresp=2'b10, m1_bresp stays 0.
REQ-033 Bench: continuous requests from both masters for 8 transactions -> strict alternation, no master granted twice in a row.
REQ-034 Bench: rst low during RDATA -> busy 0 and all valids 0 asynchronously; next request served normally.
